multi_cycle_mips_core: RTL

Parametrised multi-cycle MIPS core: the next generation of the single-cycle `data_path`. It contains the datapath, the main control FSM, the ALU decoder and the register file. Instruction fetch and data access share one memory port with a req/ready handshake, so memory may insert wait states. Each instruction takes 3–5 cycles plus memory wait cycles. The core is the top of the processor below the memory/SoC wrapper.

---
 rtl/multi_cycle_mips_core_if.sv | 39 +++
 rtl/multi_cycle_mips_core.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_mips_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_mips_core_if
//  Description : Shared instruction/data memory port of the multi-cycle core.
//                A single req/ready handshake. The access completes on a
//                rising edge where mem_req and mem_ready are both high.
//                master : core side (drives request, address, write data)
//                slave  : memory side (drives ready and read data)
//  Revision    : 1.0 - initial release
// ============================================================================
interface multi_cycle_mips_core_if #(
    parameter int n_bits = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [n_bits-1:0] mem_addr;
    logic [n_bits-1:0] mem_wdata;
    logic [n_bits-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_mips_core.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_mips_core
//  Description : Multi-cycle MIPS subset core (add/sub/and/or/slt, addi, lw,
//                sw, beq, j) with main control FSM, ALU decoder, ALU and a
//                32-entry register file. Fetch and data access share one
//                memory port that may insert wait states.
//  Ports       : clk      - clock, rising edge
//                reset_n  - asynchronous active-low reset
//                mem      - shared memory port (master side)
//                pc       - address of the current or next fetch
//                retire   - one-cycle pulse per completed instruction
//                illegal  - sticky flag, unsupported opcode/funct seen
//                state    - FSM state for debug
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_mips_core #(
    parameter int                n_bits   = 32,
    parameter logic [n_bits-1:0] RESET_PC = '0
) (
    input  wire                     clk,
    input  wire                     reset_n,
    multi_cycle_mips_core_if.master mem,
    output logic [n_bits-1:0]       pc,
    output logic                    retire,
    output logic                    illegal,
    output logic [2:0]              state
);

    // FSM state encoding
    localparam logic [2:0] C_S_FETCH  = 3'd0;
    localparam logic [2:0] C_S_DECODE = 3'd1;
    localparam logic [2:0] C_S_EXEC   = 3'd2;
    localparam logic [2:0] C_S_MEM    = 3'd3;
    localparam logic [2:0] C_S_WB     = 3'd4;
    localparam logic [2:0] C_S_TRAP   = 3'd5;

    // Opcodes
    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_J     = 6'h02;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_ADDI  = 6'h08;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] C_FN_ADD = 6'h20;
    localparam logic [5:0] C_FN_SUB = 6'h22;
    localparam logic [5:0] C_FN_AND = 6'h24;
    localparam logic [5:0] C_FN_OR  = 6'h25;
    localparam logic [5:0] C_FN_SLT = 6'h2A;

    // ALU control encoding (shared with the single-cycle data_path)
    localparam logic [2:0] C_ALU_ADD = 3'b010;
    localparam logic [2:0] C_ALU_SUB = 3'b110;
    localparam logic [2:0] C_ALU_AND = 3'b000;
    localparam logic [2:0] C_ALU_OR  = 3'b001;
    localparam logic [2:0] C_ALU_SLT = 3'b111;

    // ------------------------------------------------------------------
    // Architectural / internal registers
    // ------------------------------------------------------------------
    logic [2:0]        state_q,   state_d;
    logic [n_bits-1:0] pc_q,      pc_d;
    logic [31:0]       ir_q,      ir_d;
    logic [n_bits-1:0] a_q,       a_d;
    logic [n_bits-1:0] b_q,       b_d;
    logic [n_bits-1:0] aluout_q,  aluout_d;
    logic [n_bits-1:0] mdr_q,     mdr_d;
    logic              retire_q,  retire_d;
    logic              illegal_q, illegal_d;
    // Low during reset and for the first clock after release, so the first
    // fetch request appears only once the core is out of reset.
    logic              started_q;
    logic [n_bits-1:0] rf_q [32];

    // Register-file write port
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [n_bits-1:0] rf_wdata;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]        w_opcode;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [5:0]        w_funct;
    logic [n_bits-1:0] w_simm;
    logic [n_bits-1:0] w_rs_val;
    logic [n_bits-1:0] w_rt_val;

    assign w_opcode = ir_q[31:26];
    assign w_rs     = ir_q[25:21];
    assign w_rt     = ir_q[20:16];
    assign w_rd     = ir_q[15:11];
    assign w_funct  = ir_q[5:0];
    assign w_simm   = {{(n_bits-16){ir_q[15]}}, ir_q[15:0]};

    // $0 is never written and is cleared by reset, so it always reads zero.
    assign w_rs_val = rf_q[w_rs];
    assign w_rt_val = rf_q[w_rt];

    // ------------------------------------------------------------------
    // Legality check and ALU decoder
    // ------------------------------------------------------------------
    logic w_funct_ok;
    logic w_legal;
    logic [2:0] w_alu_ctl;

    always_comb begin
        w_funct_ok = 1'b0;
        w_alu_ctl  = C_ALU_ADD;
        case (w_funct)
            C_FN_ADD: begin w_funct_ok = 1'b1; w_alu_ctl = C_ALU_ADD; end
            C_FN_SUB: begin w_funct_ok = 1'b1; w_alu_ctl = C_ALU_SUB; end
            C_FN_AND: begin w_funct_ok = 1'b1; w_alu_ctl = C_ALU_AND; end
            C_FN_OR:  begin w_funct_ok = 1'b1; w_alu_ctl = C_ALU_OR;  end
            C_FN_SLT: begin w_funct_ok = 1'b1; w_alu_ctl = C_ALU_SLT; end
            default:  begin w_funct_ok = 1'b0; w_alu_ctl = C_ALU_ADD; end
        endcase
        // Everything other than R-type uses the ALU as an adder.
        if (w_opcode != C_OP_RTYPE) begin
            w_alu_ctl = C_ALU_ADD;
        end
    end

    always_comb begin
        case (w_opcode)
            C_OP_RTYPE: w_legal = w_funct_ok;
            C_OP_J,
            C_OP_BEQ,
            C_OP_ADDI,
            C_OP_LW,
            C_OP_SW:    w_legal = 1'b1;
            default:    w_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [n_bits-1:0] w_alu_b;
    logic [n_bits-1:0] w_alu_y;

    assign w_alu_b = (w_opcode == C_OP_RTYPE) ? b_q : w_simm;

    always_comb begin
        case (w_alu_ctl)
            C_ALU_ADD: w_alu_y = a_q + w_alu_b;
            C_ALU_SUB: w_alu_y = a_q - w_alu_b;
            C_ALU_AND: w_alu_y = a_q & w_alu_b;
            C_ALU_OR:  w_alu_y = a_q | w_alu_b;
            C_ALU_SLT: w_alu_y = {{(n_bits-1){1'b0}}, ($signed(a_q) < $signed(w_alu_b))};
            default:   w_alu_y = a_q + w_alu_b;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory port: outputs depend only on registered state, so they are
    // naturally stable for the whole duration of a stalled access.
    // ------------------------------------------------------------------
    logic w_mem_done;

    assign mem.mem_req   = started_q && ((state_q == C_S_FETCH) || (state_q == C_S_MEM));
    assign mem.mem_we    = (state_q == C_S_MEM) && (w_opcode == C_OP_SW);
    assign mem.mem_addr  = (state_q == C_S_MEM) ? aluout_q : pc_q;
    assign mem.mem_wdata = b_q;
    assign w_mem_done    = mem.mem_req && mem.mem_ready;

    // ------------------------------------------------------------------
    // Main control FSM and datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        aluout_d  = aluout_q;
        mdr_d     = mdr_q;
        retire_d  = 1'b0;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_waddr  = w_rt;
        rf_wdata  = aluout_q;

        case (state_q)
            C_S_FETCH: begin
                if (w_mem_done) begin
                    ir_d    = mem.mem_rdata[31:0];
                    pc_d    = pc_q + n_bits'(4);
                    state_d = C_S_DECODE;
                end
            end

            C_S_DECODE: begin
                if (w_legal) begin
                    a_d      = w_rs_val;
                    b_d      = w_rt_val;
                    // Branch target precomputed from the already-incremented pc.
                    aluout_d = pc_q + {w_simm[n_bits-3:0], 2'b00};
                    state_d  = C_S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = C_S_TRAP;
                end
            end

            C_S_EXEC: begin
                case (w_opcode)
                    C_OP_RTYPE,
                    C_OP_ADDI: begin
                        aluout_d = w_alu_y;
                        state_d  = C_S_WB;
                    end
                    C_OP_LW,
                    C_OP_SW: begin
                        aluout_d = w_alu_y;
                        state_d  = C_S_MEM;
                    end
                    C_OP_BEQ: begin
                        if (a_q == b_q) begin
                            pc_d = aluout_q;
                        end
                        retire_d = 1'b1;
                        state_d  = C_S_FETCH;
                    end
                    C_OP_J: begin
                        pc_d     = {pc_q[n_bits-1:28], ir_q[25:0], 2'b00};
                        retire_d = 1'b1;
                        state_d  = C_S_FETCH;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = C_S_TRAP;
                    end
                endcase
            end

            C_S_MEM: begin
                if (w_mem_done) begin
                    if (w_opcode == C_OP_SW) begin
                        retire_d = 1'b1;
                        state_d  = C_S_FETCH;
                    end else begin
                        mdr_d   = mem.mem_rdata;
                        state_d = C_S_WB;
                    end
                end
            end

            C_S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (w_opcode == C_OP_RTYPE) ? w_rd : w_rt;
                rf_wdata = (w_opcode == C_OP_LW) ? mdr_q : aluout_q;
                retire_d = 1'b1;
                state_d  = C_S_FETCH;
            end

            C_S_TRAP: begin
                state_d = C_S_TRAP;
            end

            default: begin
                illegal_d = 1'b1;
                state_d   = C_S_TRAP;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers and register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= C_S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            aluout_q  <= '0;
            mdr_q     <= '0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            started_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            aluout_q  <= aluout_d;
            mdr_q     <= mdr_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            started_q <= 1'b1;
            if (rf_we && (rf_waddr != 5'd0)) begin
                rf_q[rf_waddr] <= rf_wdata;
            end
        end
    end

    assign pc      = pc_q;
    assign retire  = retire_q;
    assign illegal = illegal_q;
    assign state   = state_q;

endmodule
`default_nettype wire
